// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, completion codes and the
// keyboard command bytes used by the host side.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StShift,
    StAck,
    StWaitIdle,
    StDone
  } tx_state_e;

  typedef enum logic [1:0] {
    ErrOk      = 2'b00,
    ErrStartTo = 2'b01,
    ErrFrameTo = 2'b10,
    ErrNack    = 2'b11
  } tx_err_e;

  localparam logic [7:0] CmdSetLed    = 8'hED;
  localparam logic [7:0] CmdTypematic = 8'hF3;
  localparam logic [7:0] CmdReset     = 8'hFF;
  localparam logic [7:0] RspAck       = 8'hFA;

  // Parity bit that makes the count of ones over data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
//   tx_data/tx_valid : byte and request (requester -> transmitter)
//   tx_ready/tx_busy : idle / transaction in progress
//   tx_done/tx_err   : end-of-transaction pulse and its completion code
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic [1:0] tx_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_busy, tx_done, tx_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_busy, tx_done, tx_err
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one asynchronous PS/2 pad line plus a falling-edge
// detector on the synchronised value. Flops reset to 1 (idle line level).
//   clk, rst : system clock, asynchronous active-high reset
//   line_i   : raw pad input
//   line_o   : synchronised level
//   fall_o   : one-cycle pulse when line_o goes 1 -> 0
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic line_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign line_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues request-to-send,
// shifts start/data/parity/stop out on device clock falls, samples the device
// ACK and reports completion with a code.
//   clk, rst                 : system clock, asynchronous active-high reset
//   tx_if (slave)            : command handshake and completion report
//   ps2_clk_in, ps2_data_in  : raw pad levels (asynchronous)
//   ps2_clk_oe, ps2_data_oe  : 1 pulls the open-drain line low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned FRAME_TIMEOUT  = 100000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  tx_if,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam logic [CNT_W-1:0] InhibitLast = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] StartLast   = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FrameLast   = CNT_W'(FRAME_TIMEOUT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  tx_err_e          err_q, err_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;

  logic clk_sync, clk_fall, data_sync;
  // The transmitter has no use for data-line edges.
  logic unused_data_fall;

  ps2_line_sync u_clk_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2_clk_in),
    .line_o (clk_sync),
    .fall_o (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2_data_in),
    .line_o (data_sync),
    .fall_o (unused_data_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      err_q     <= ErrOk;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      err_q     <= err_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    err_d     = err_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;

    unique case (state_q)
      StIdle: begin
        if (tx_if.tx_valid) begin
          state_d   = StInhibit;
          shift_d   = {odd_parity(tx_if.tx_data), tx_if.tx_data};
          bitcnt_d  = '0;
          timer_d   = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
        end
      end
      StInhibit: begin
        if (timer_q == InhibitLast) begin
          // Release clock and assert the start bit together.
          state_d   = StRts;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRts: begin
        if (clk_fall) begin
          state_d   = StShift;
          data_oe_d = ~shift_q[0];
          bitcnt_d  = 4'd1;
          timer_d   = '0;
        end else if (timer_q == StartLast) begin
          state_d   = StDone;
          err_d     = ErrStartTo;
          data_oe_d = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StShift: begin
        if (timer_q == FrameLast) begin
          state_d   = StDone;
          err_d     = ErrFrameTo;
          data_oe_d = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
          if (clk_fall) begin
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd9) begin
              data_oe_d = 1'b0;  // stop bit: release
              state_d   = StAck;
            end else begin
              data_oe_d = ~shift_q[bitcnt_q];
            end
          end
        end
      end
      StAck: begin
        if (timer_q == FrameLast) begin
          state_d   = StDone;
          err_d     = ErrFrameTo;
          data_oe_d = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
          if (clk_fall) begin
            if (!data_sync) begin
              state_d = StWaitIdle;
            end else begin
              state_d = StDone;
              err_d   = ErrNack;
            end
          end
        end
      end
      StWaitIdle: begin
        if (clk_sync && data_sync) begin
          state_d = StDone;
          err_d   = ErrOk;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase
  end

  assign tx_if.tx_ready = (state_q == StIdle);
  assign tx_if.tx_busy  = (state_q != StIdle);
  assign tx_if.tx_done  = (state_q == StDone);
  assign tx_if.tx_err   = err_q;
  assign ps2_clk_oe     = clk_oe_q;
  assign ps2_data_oe    = data_oe_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends command bytes (LED set 0xED, reset 0xFF, typematic 0xF3) from the Apple keyboard subsystem to the attached keyboard. It is the opposite direction to the existing PS/2 keyboard receive path: it shares the same ps2_clk and ps2_data open-drain lines. It performs the inhibit and request-to-send sequence, shifts the frame out on device-generated clocks, checks the device ACK, and reports done or error.

Parameters:
INHIBIT_CYCLES, 5000, clock-low hold before request-to-send (100 us at 50 MHz).
START_TIMEOUT, 750000, max cycles from clock release to first device falling edge (15 ms).
FRAME_TIMEOUT, 100000, max cycles from first device falling edge to ACK sampled (2 ms).
CNT_W, 20, width of shared timer; must hold max(INHIBIT_CYCLES, START_TIMEOUT, FRAME_TIMEOUT).

Ports:
clk  in  1  system clock (CLK50MHZ domain).
rst  in  1  asynchronous, active-high reset.
tx_data  in  8  byte to send.
tx_valid  in  1  request; accepted when tx_valid && tx_ready.
tx_ready  out  1  high only in IDLE.
tx_busy  out  1  high in any non-IDLE state; the receive path ignores the lines while high.
tx_done  out  1  one-cycle pulse at end of every transaction (success or error).
tx_err  out  2  valid with tx_done: 00 ok, 01 start timeout, 10 frame timeout, 11 NACK.
ps2_clk_in  in  1  raw pad clock (asynchronous).
ps2_data_in  in  1  raw pad data (asynchronous).
ps2_clk_oe  out  1  1 = pull clock low; 0 = release.
ps2_data_oe  out  1  1 = pull data low; 0 = release.

Behaviour:
- Reset (async, immediate): state=IDLE; tx_ready=1; tx_busy=0; tx_done=0; tx_err=00; both oe=0 (lines released, including mid-frame); synchronisers=11; counters=0.
- Inputs: 2-FF synchroniser on each line. A clock fall is registered when the synchronised clock goes 1 to 0. Edge response latency is 3 clk cycles maximum.
- Acceptance: on a tx_valid && tx_ready cycle, the block latches tx_data, sets shift = {~^tx_data, tx_data} (odd parity in bit 8), clears bitcnt, and enters INHIBIT on the next edge. tx_valid while busy is ignored.
- INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles.
- RTS: entered after INHIBIT. data_oe=1 (start bit 0) on the same cycle that clk_oe drops to 0. Timer restarts.
  - Clock fall: enter SHIFT and drive bit 0.
  - START_TIMEOUT expires: err=01.
- SHIFT: on each clock fall, the block sets data_oe = ~shift[bitcnt] for bitcnt 0..8. On bitcnt 9 (stop) it sets data_oe=0. bitcnt increments after each fall. Data changes only while the device clock is low.
- ACK: entered after the stop bit has been driven. The next clock fall samples ps2_data_in (synchronised).
  - Sample 0: WAIT_IDLE.
  - Sample 1: err=11.
- WAIT_IDLE: wait until synchronised clock=1 and data=1, then DONE with err=00.
- Frame timer: runs from the first clock fall to the ACK sample. Expiry in SHIFT or ACK gives err=10.
- ERROR path: release both lines. Pulse tx_done with code, then return to IDLE.
- DONE: tx_done=1 for one cycle, tx_err held until the next tx_done. Next cycle is IDLE with tx_ready=1.
- tx_busy=1 from the cycle after acceptance through the DONE cycle inclusive.
- Device pulling the clock low during INHIBIT has no effect (the host owns the line).
- A clock fall while in RTS before the timer starts counts normally.
- All state encodings are one-hot or binary; this is not observable.

Decomposition:
- Shared package ps2_pkg holds:
  - state enum (IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE, DONE);
  - tx_err codes;
  - command constants 0xED, 0xF3, 0xFF, 0xFA.
- One sub-module, ps2_line_sync: 2-FF synchroniser plus falling-edge detect, reused by the receiver.

Test Plan:
1. Send 0xED with INHIBIT_CYCLES=50; bench device model clocks at 10 kHz and ACKs.
   - clk_oe low 50 cycles, then start bit.
   - Device captures bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1.
   - tx_done with err=00.
2. Send 0x01 -> device captures parity 0. Send 0x00 -> parity 1. Send 0xFF -> parity 1. All end with err=00.
3. Device returns data=1 at the ACK clock -> tx_done with err=11, both oe=0, tx_ready=1 next cycle.
4. Device never clocks, START_TIMEOUT=200 -> tx_done with err=01 exactly 200 cycles after RTS entry; lines released.
5. Device stops after 4 clocks, FRAME_TIMEOUT=500 -> err=10.
6. Assert rst mid-SHIFT -> both oe=0 asynchronously, tx_ready=1.
   - tx_valid held during busy is not accepted.
   - Back-to-back request after DONE is accepted in IDLE.
